// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU encodings, bus widths and the memory-stage FSM state type
package cpu_pkg;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 30;
  localparam int REG_ADDR_W = 5;
  localparam logic [1:0] MEM_OP_NOP = 2'd0;
  localparam logic [1:0] MEM_OP_LDW = 2'd1;
  localparam logic [1:0] MEM_OP_STW = 2'd2;
  localparam logic [2:0] EXP_NO = 3'd0;
  localparam logic [2:0] EXP_MISS_ALIGN = 3'd4;
  localparam logic [2:0] EXP_BUS_ERR = 3'd5;
  localparam logic [1:0] CTRL_OP_NOP = 2'd0;
  localparam logic [1:0] CTRL_OP_WRCR = 2'd1;
  localparam logic [1:0] CTRL_OP_EXRT = 2'd2;
  typedef enum logic {IDLE, ACCESS} mem_state_e;
endpackage

// File: rtl/mem_stage_ctrl.sv
// mem_ctrl: bus access FSM with timeout, busy generation and a result hold register for stalls
module mem_ctrl
  import cpu_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 30,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush_any,
  input  logic              req,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wr_data,
  output logic              bus_as,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [WORD_W-1:0] bus_wr_data,
  input  logic [WORD_W-1:0] bus_rd_data,
  input  logic              bus_rdy,
  output logic              busy,
  output logic              res_v,
  output logic [WORD_W-1:0] res_data,
  output logic              res_err,
  output logic              res_kill
);
  localparam int TW = $clog2(TIMEOUT);
  mem_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d, hold_data_q, hold_data_d;
  logic rw_q, rw_d, kill_q, kill_d, hold_v_q, hold_v_d, hold_err_q, hold_err_d, hold_kill_q, hold_kill_d;
  logic start, complete, consume;
  // A finished result is consumed unless stalled; an unconsumed one parks in the hold reg and blocks a restart
  always_comb begin
    complete = state_q == ACCESS && (bus_rdy || timer_q == TW'(TIMEOUT - 1));
    start = state_q == IDLE && !hold_v_q && req && !flush_any;
    busy = start || (state_q == ACCESS && !complete);
    res_v = complete || hold_v_q;
    res_data = hold_v_q ? hold_data_q : bus_rd_data;
    res_err = hold_v_q ? hold_err_q : !bus_rdy;
    res_kill = hold_v_q ? hold_kill_q : kill_q;
    consume = res_v && (flush_any || !stall);
    state_d = start ? ACCESS : complete ? IDLE : state_q;
    timer_d = (state_q == ACCESS && !complete) ? timer_q + 1'b1 : '0;
    addr_d = start ? req_addr : addr_q;
    rw_d = start ? req_rw : rw_q;
    wr_data_d = start ? req_wr_data : wr_data_q;
    kill_d = consume ? 1'b0 : kill_q || (flush_any && state_q == ACCESS);
    hold_v_d = res_v && !consume;
    hold_data_d = res_data;
    hold_err_d = res_err;
    hold_kill_d = res_kill;
    bus_as = state_q == ACCESS;
    bus_rw = rw_q;
    bus_addr = addr_q;
    bus_wr_data = wr_data_q;
  end
  // FSM, timer, bus and hold registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      addr_q <= '0;
      rw_q <= 1'b0;
      wr_data_q <= '0;
      kill_q <= 1'b0;
      hold_v_q <= 1'b0;
      hold_data_q <= '0;
      hold_err_q <= 1'b0;
      hold_kill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      addr_q <= addr_d;
      rw_q <= rw_d;
      wr_data_q <= wr_data_d;
      kill_q <= kill_d;
      hold_v_q <= hold_v_d;
      hold_data_q <= hold_data_d;
      hold_err_q <= hold_err_d;
      hold_kill_q <= hold_kill_d;
    end
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage performing loads/stores and holding the MEM/WB register
module mem_stage
  import cpu_pkg::*;
#(
  parameter int WORD_W = cpu_pkg::WORD_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  int_detect,
  input  logic [ADDR_W-1:0]     ex_pc,
  input  logic                  ex_en,
  input  logic                  ex_br_flag,
  input  logic [1:0]            ex_mem_op,
  input  logic [WORD_W-1:0]     ex_mem_wr_data,
  input  logic [1:0]            ex_ctrl_op,
  input  logic [REG_ADDR_W-1:0] ex_dst_addr,
  input  logic                  ex_gpr_we_,
  input  logic [2:0]            ex_exp_code,
  input  logic [WORD_W-1:0]     ex_out,
  output logic                  bus_as,
  output logic                  bus_rw,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [WORD_W-1:0]     bus_wr_data,
  input  logic [WORD_W-1:0]     bus_rd_data,
  input  logic                  bus_rdy,
  output logic                  busy,
  output logic [WORD_W-1:0]     fwd_data,
  output logic [ADDR_W-1:0]     mem_pc,
  output logic                  mem_en,
  output logic                  mem_br_flag,
  output logic [1:0]            mem_ctrl_op,
  output logic [REG_ADDR_W-1:0] mem_dst_addr,
  output logic                  mem_gpr_we_,
  output logic [2:0]            mem_exp_code,
  output logic [WORD_W-1:0]     mem_out
);
  logic flush_any, is_mem, is_ld, req, misal, bubble, hold, force_no_we;
  logic res_v, res_err, res_kill;
  logic [WORD_W-1:0] res_data;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [REG_ADDR_W-1:0] dst_q, dst_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic [2:0] exp_q, exp_d;
  logic [WORD_W-1:0] out_q, out_d;
  logic en_q, en_d, br_q, br_d, we_q, we_d;
  mem_ctrl #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) u_ctrl (
    .clk(clk), .reset(reset), .stall(stall), .flush_any(flush_any),
    .req(req), .req_rw(is_ld), .req_addr(ex_out[ADDR_W+1:2]), .req_wr_data(ex_mem_wr_data),
    .bus_as(bus_as), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy(bus_rdy), .busy(busy),
    .res_v(res_v), .res_data(res_data), .res_err(res_err), .res_kill(res_kill)
  );
  // MEM/WB next state: flush bubble, then hold on stall/busy, then a killed access becomes a bubble
  always_comb begin
    flush_any = flush || int_detect;
    is_mem = ex_en && ex_mem_op != MEM_OP_NOP && ex_exp_code == EXP_NO;
    is_ld = ex_mem_op == MEM_OP_LDW;
    req = is_mem && ex_out[1:0] == 2'b00;
    misal = is_mem && ex_out[1:0] != 2'b00;
    force_no_we = misal || (is_mem && !is_ld) || (req && res_err);
    fwd_data = (req && is_ld && res_v) ? res_data : ex_out;
    bubble = flush_any || (!stall && req && res_v && res_kill);
    hold = stall || busy;
    pc_d = bubble ? '0 : hold ? pc_q : ex_pc;
    en_d = bubble ? 1'b0 : hold ? en_q : ex_en;
    br_d = bubble ? 1'b0 : hold ? br_q : ex_br_flag;
    ctrl_d = bubble ? '0 : hold ? ctrl_q : ex_ctrl_op;
    dst_d = bubble ? '0 : hold ? dst_q : ex_dst_addr;
    we_d = bubble ? 1'b1 : hold ? we_q : force_no_we || ex_gpr_we_;
    exp_d = bubble ? EXP_NO : hold ? exp_q : misal ? EXP_MISS_ALIGN : (req && res_err) ? EXP_BUS_ERR : ex_exp_code;
    out_d = bubble ? '0 : hold ? out_q : fwd_data;
    mem_pc = pc_q;
    mem_en = en_q;
    mem_br_flag = br_q;
    mem_ctrl_op = ctrl_q;
    mem_dst_addr = dst_q;
    mem_gpr_we_ = we_q;
    mem_exp_code = exp_q;
    mem_out = out_q;
  end
  // MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
      en_q <= 1'b0;
      br_q <= 1'b0;
      ctrl_q <= '0;
      dst_q <= '0;
      we_q <= 1'b1;
      exp_q <= EXP_NO;
      out_q <= '0;
    end else begin
      pc_q <= pc_d;
      en_q <= en_d;
      br_q <= br_d;
      ctrl_q <= ctrl_d;
      dst_q <= dst_d;
      we_q <= we_d;
      exp_q <= exp_d;
      out_q <= out_d;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of load/store, misalignment, timeout, flush, stall and reset
module tb_mem_stage;
  import cpu_pkg::*;
  logic clk = 0, reset = 1, stall = 0, flush = 0, int_detect = 0;
  logic [29:0] ex_pc = 0;
  logic ex_en = 0, ex_br_flag = 0, ex_gpr_we_ = 1;
  logic [1:0] ex_mem_op = 0, ex_ctrl_op = 0;
  logic [31:0] ex_mem_wr_data = 0, ex_out = 0, bus_rd_data = 0;
  logic [4:0] ex_dst_addr = 0;
  logic [2:0] ex_exp_code = 0;
  logic bus_as, bus_rw, bus_rdy = 0, busy;
  logic [29:0] bus_addr, mem_pc;
  logic [31:0] bus_wr_data, fwd_data, mem_out;
  logic mem_en, mem_br_flag, mem_gpr_we_;
  logic [1:0] mem_ctrl_op;
  logic [4:0] mem_dst_addr;
  logic [2:0] mem_exp_code;
  int checks = 0, errors = 0, nbusy, nas;
  logic [29:0] a_addr;
  logic a_rw, a_stable;
  logic [31:0] a_wd;

  mem_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .int_detect(int_detect),
    .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
    .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
    .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
    .bus_as(bus_as), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy(bus_rdy), .busy(busy), .fwd_data(fwd_data),
    .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
    .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
    .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic set_ex(input logic [1:0] op, input logic [31:0] out, input logic [31:0] wd, input logic [4:0] dst);
    ex_en = 1; ex_mem_op = op; ex_out = out; ex_mem_wr_data = wd; ex_dst_addr = dst;
    ex_gpr_we_ = 0; ex_exp_code = EXP_NO;
  endtask

  // Called just after a negedge with EX driven; returns just after the negedge following completion
  task automatic run_access(input int rdy_at, input logic [31:0] rd, input int flush_at, input int stall_at);
    bit done = 0;
    nbusy = 0; nas = 0; a_stable = 1;
    bus_rd_data = rd;
    for (int c = 0; c < 40 && !done; c++) begin
      bus_rdy = bus_as && nas + 1 == rdy_at;
      flush = flush_at > 0 && bus_as && nas + 1 == flush_at;
      stall = stall_at > 0 && bus_as && nas + 1 >= stall_at;
      if (bus_as) begin
        nas++;
        if (nas == 1) begin
          a_addr = bus_addr; a_rw = bus_rw; a_wd = bus_wr_data;
        end else if (bus_addr != a_addr || bus_rw != a_rw || bus_wr_data != a_wd) a_stable = 0;
      end
      #1;
      if (busy) nbusy++;
      else done = 1;
      @(negedge clk);
    end
    check("access_terminates", 32'(done), 32'd1);
    bus_rdy = 0; flush = 0; stall = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_gpr_we_", 32'(mem_gpr_we_), 1);
    check("rst_exp", 32'(mem_exp_code), 32'(EXP_NO));
    check("rst_bus_as", 32'(bus_as), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 0;
    @(negedge clk);
    // load, ready in third bus cycle
    set_ex(MEM_OP_LDW, 32'h100, 0, 5'd3);
    ex_pc = 30'h40; ex_ctrl_op = CTRL_OP_EXRT; ex_br_flag = 1;
    run_access(3, 32'h1234_5678, 0, 0);
    check("ld_busy_cycles", nbusy, 3);
    check("ld_as_cycles", nas, 3);
    check("ld_bus_addr", 32'(a_addr), 32'h40);
    check("ld_bus_rw", 32'(a_rw), 1);
    check("ld_bus_stable", 32'(a_stable), 1);
    check("ld_mem_out", mem_out, 32'h1234_5678);
    check("ld_mem_en", 32'(mem_en), 1);
    check("ld_gpr_we_", 32'(mem_gpr_we_), 0);
    check("ld_dst", 32'(mem_dst_addr), 3);
    check("ld_pc", 32'(mem_pc), 32'h40);
    check("ld_ctrl_op", 32'(mem_ctrl_op), 32'(CTRL_OP_EXRT));
    check("ld_br_flag", 32'(mem_br_flag), 1);
    check("ld_exp", 32'(mem_exp_code), 32'(EXP_NO));
    ex_ctrl_op = 0; ex_br_flag = 0;
    // store
    set_ex(MEM_OP_STW, 32'h104, 32'hDEAD_BEEF, 5'd4);
    run_access(2, 32'h0, 0, 0);
    check("st_busy_cycles", nbusy, 2);
    check("st_bus_rw", 32'(a_rw), 0);
    check("st_bus_addr", 32'(a_addr), 32'h41);
    check("st_wr_data", a_wd, 32'hDEAD_BEEF);
    check("st_bus_stable", 32'(a_stable), 1);
    check("st_gpr_we_", 32'(mem_gpr_we_), 1);
    check("st_mem_out", mem_out, 32'h104);
    // misaligned load
    set_ex(MEM_OP_LDW, 32'h102, 0, 5'd6);
    run_access(0, 32'h0, 0, 0);
    check("mis_busy_cycles", nbusy, 0);
    check("mis_as_cycles", nas, 0);
    check("mis_exp", 32'(mem_exp_code), 32'(EXP_MISS_ALIGN));
    check("mis_gpr_we_", 32'(mem_gpr_we_), 1);
    check("mis_mem_en", 32'(mem_en), 1);
    // timeout
    set_ex(MEM_OP_LDW, 32'h200, 0, 5'd7);
    run_access(0, 32'h0, 0, 0);
    check("to_as_cycles", nas, 16);
    check("to_busy_cycles", nbusy, 16);
    check("to_exp", 32'(mem_exp_code), 32'(EXP_BUS_ERR));
    check("to_gpr_we_", 32'(mem_gpr_we_), 1);
    ex_en = 0;
    #1;
    check("to_idle_as", 32'(bus_as), 0);
    check("to_idle_busy", 32'(busy), 0);
    @(negedge clk);
    // flush one cycle into the access
    set_ex(MEM_OP_LDW, 32'h300, 0, 5'd5);
    run_access(3, 32'h5555_AAAA, 1, 0);
    check("fl_busy_cycles", nbusy, 3);
    check("fl_as_cycles", nas, 3);
    check("fl_mem_en", 32'(mem_en), 0);
    check("fl_gpr_we_", 32'(mem_gpr_we_), 1);
    check("fl_mem_out", mem_out, 0);
    // stall across completion, result delivered once stall drops
    set_ex(MEM_OP_LDW, 32'h400, 0, 5'd9);
    run_access(2, 32'hCAFE_F00D, 0, 1);
    check("stl_busy_cycles", nbusy, 2);
    #1;
    check("stl_held_en", 32'(mem_en), 0);
    check("stl_hold_busy", 32'(busy), 0);
    check("stl_no_restart", 32'(bus_as), 0);
    check("stl_fwd", fwd_data, 32'hCAFE_F00D);
    @(negedge clk);
    check("stl_mem_out", mem_out, 32'hCAFE_F00D);
    check("stl_mem_en", 32'(mem_en), 1);
    check("stl_dst", 32'(mem_dst_addr), 9);
    // non-memory op, stray bus_rdy ignored
    set_ex(MEM_OP_NOP, 32'hABCD, 0, 5'd2);
    bus_rdy = 1;
    #1;
    check("nop_busy", 32'(busy), 0);
    check("nop_fwd", fwd_data, 32'hABCD);
    @(negedge clk);
    bus_rdy = 0;
    check("nop_mem_out", mem_out, 32'hABCD);
    check("nop_gpr_we_", 32'(mem_gpr_we_), 0);
    check("nop_rdy_idle_as", 32'(bus_as), 0);
    stall = 1; ex_out = 32'h1111;
    @(negedge clk);
    check("nop_stall_hold", mem_out, 32'hABCD);
    stall = 0;
    // reset in the middle of an access
    set_ex(MEM_OP_LDW, 32'h500, 0, 5'd1);
    repeat (2) @(negedge clk);
    check("rm_as_before", 32'(bus_as), 1);
    reset = 1; ex_en = 0;
    @(negedge clk);
    check("rm_bus_as", 32'(bus_as), 0);
    check("rm_busy", 32'(busy), 0);
    check("rm_mem_en", 32'(mem_en), 0);
    check("rm_mem_out", mem_out, 0);
    check("rm_gpr_we_", 32'(mem_gpr_we_), 1);
    check("rm_exp", 32'(mem_exp_code), 32'(EXP_NO));
    reset = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
